pipe_mips: RTL and testbench

// - 5-stage in-order 32-bit RISC core (IF, ID, EX, MEM, WB) with unified word-addressed instruction/data memory.
// - Standalone top of the processor; programs and data are preloaded hierarchically into internal arrays before reset release.
// - Runs until a HLT instruction retires, then freezes.

---
 rtl/pipe_mips.sv | 216 +++++++++++++++++++++
 tb/tb_pipe_mips.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mips.sv
// 5-stage in-order 32-bit RISC core with unified word-addressed memory.
// Full EX-stage forwarding, no load-use interlock, branches resolved in EX.
module pipe_mips #(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic clk,
    input  logic rst,
    output logic halted
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    typedef enum logic [5:0] {
        OP_ADD   = 6'b000000,
        OP_SUB   = 6'b000001,
        OP_AND   = 6'b000010,
        OP_OR    = 6'b000011,
        OP_SLT   = 6'b000100,
        OP_MUL   = 6'b000101,
        OP_LW    = 6'b001000,
        OP_SW    = 6'b001001,
        OP_ADDI  = 6'b001010,
        OP_SUBI  = 6'b001011,
        OP_SLTI  = 6'b001100,
        OP_BNEQZ = 6'b001101,
        OP_BEQZ  = 6'b001110,
        OP_HLT   = 6'b111111
    } op_e;

    logic [31:0] reg_bank [0:31];
    logic [31:0] inst_mem [0:MEM_DEPTH-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;
    logic        stop_fetch_q;

    logic        if_id_valid_q;
    logic [31:0] if_id_ir_q;
    logic [31:0] if_id_npc_q;

    logic        id_ex_valid_q;
    op_e         id_ex_op_q;
    logic [4:0]  id_ex_rs_q;
    logic [4:0]  id_ex_rt_q;
    logic [4:0]  id_ex_dest_q;
    logic        id_ex_we_q;
    logic [31:0] id_ex_a_q;
    logic [31:0] id_ex_b_q;
    logic [31:0] id_ex_imm_q;
    logic [31:0] id_ex_npc_q;

    logic        ex_mem_valid_q;
    op_e         ex_mem_op_q;
    logic [4:0]  ex_mem_dest_q;
    logic        ex_mem_we_q;
    logic [31:0] ex_mem_alu_q;
    logic [31:0] ex_mem_b_q;

    logic        mem_wb_valid_q;
    op_e         mem_wb_op_q;
    logic [4:0]  mem_wb_dest_q;
    logic        mem_wb_we_q;
    logic [31:0] mem_wb_data_q;

    logic        wb_we;
    op_e         id_op_d;
    logic [4:0]  id_rs_d;
    logic [4:0]  id_rt_d;
    logic [4:0]  id_dest_d;
    logic        id_we_d;
    logic        id_hlt_d;
    logic [31:0] id_a_d;
    logic [31:0] id_b_d;
    logic [31:0] id_imm_d;

    logic        ex_fwd_mem;
    logic [31:0] ex_a_d;
    logic [31:0] ex_b_d;
    logic [31:0] ex_alu_d;
    logic        ex_taken_d;
    logic [31:0] ex_target_d;

    logic [31:0] mem_rdata;
    logic        mem_store;

    assign halted = HALTED;
    assign wb_we  = mem_wb_valid_q && mem_wb_we_q;

    // Decode; register reads see a same-cycle WB write (write-through).
    always_comb begin
        id_op_d   = op_e'(if_id_ir_q[31:26]);
        id_rs_d   = if_id_ir_q[25:21];
        id_rt_d   = if_id_ir_q[20:16];
        id_imm_d  = {{16{if_id_ir_q[15]}}, if_id_ir_q[15:0]};
        id_dest_d = '0;
        id_we_d   = 1'b0;
        case (id_op_d)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
                id_dest_d = if_id_ir_q[15:11];
                id_we_d   = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
                id_dest_d = id_rt_d;
                id_we_d   = 1'b1;
            end
            default: ;
        endcase
        if (id_dest_d == '0)
            id_we_d = 1'b0;
        id_a_d   = (wb_we && mem_wb_dest_q == id_rs_d) ? mem_wb_data_q : reg_bank[id_rs_d];
        id_b_d   = (wb_we && mem_wb_dest_q == id_rt_d) ? mem_wb_data_q : reg_bank[id_rt_d];
        id_hlt_d = if_id_valid_q && (id_op_d == OP_HLT);
    end

    // A load sitting in EX/MEM has no data yet, so it is skipped as a forwarding source.
    always_comb begin
        ex_fwd_mem = ex_mem_valid_q && ex_mem_we_q && (ex_mem_op_q != OP_LW);
        if (ex_fwd_mem && ex_mem_dest_q == id_ex_rs_q)
            ex_a_d = ex_mem_alu_q;
        else if (wb_we && mem_wb_dest_q == id_ex_rs_q)
            ex_a_d = mem_wb_data_q;
        else
            ex_a_d = id_ex_a_q;
        if (ex_fwd_mem && ex_mem_dest_q == id_ex_rt_q)
            ex_b_d = ex_mem_alu_q;
        else if (wb_we && mem_wb_dest_q == id_ex_rt_q)
            ex_b_d = mem_wb_data_q;
        else
            ex_b_d = id_ex_b_q;

        ex_alu_d = '0;
        case (id_ex_op_q)
            OP_ADD:               ex_alu_d = ex_a_d + ex_b_d;
            OP_SUB:               ex_alu_d = ex_a_d - ex_b_d;
            OP_AND:               ex_alu_d = ex_a_d & ex_b_d;
            OP_OR:                ex_alu_d = ex_a_d | ex_b_d;
            OP_SLT:               ex_alu_d = {31'd0, $signed(ex_a_d) < $signed(ex_b_d)};
            OP_MUL:               ex_alu_d = ex_a_d * ex_b_d;
            OP_ADDI, OP_LW, OP_SW: ex_alu_d = ex_a_d + id_ex_imm_q;
            OP_SUBI:              ex_alu_d = ex_a_d - id_ex_imm_q;
            OP_SLTI:              ex_alu_d = {31'd0, $signed(ex_a_d) < $signed(id_ex_imm_q)};
            default:              ex_alu_d = '0;
        endcase

        ex_taken_d  = id_ex_valid_q &&
                      (((id_ex_op_q == OP_BNEQZ) && (ex_a_d != '0)) ||
                       ((id_ex_op_q == OP_BEQZ)  && (ex_a_d == '0)));
        ex_target_d = id_ex_npc_q + id_ex_imm_q;
    end

    assign mem_rdata = inst_mem[ex_mem_alu_q[AW-1:0]];
    assign mem_store = ex_mem_valid_q && (ex_mem_op_q == OP_SW);

    always_ff @(posedge clk) begin
        if (!rst && !HALTED) begin
            if (wb_we)
                reg_bank[mem_wb_dest_q] <= mem_wb_data_q;
            if (mem_store)
                inst_mem[ex_mem_alu_q[AW-1:0]] <= ex_mem_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            PC             <= '0;
            HALTED         <= 1'b0;
            TAKEN_BRANCH   <= 1'b0;
            stop_fetch_q   <= 1'b0;
            if_id_valid_q  <= 1'b0;
            id_ex_valid_q  <= 1'b0;
            ex_mem_valid_q <= 1'b0;
            mem_wb_valid_q <= 1'b0;
        end else if (!HALTED) begin
            TAKEN_BRANCH <= ex_taken_d;
            if (mem_wb_valid_q && mem_wb_op_q == OP_HLT)
                HALTED <= 1'b1;

            mem_wb_valid_q <= ex_mem_valid_q;
            mem_wb_op_q    <= ex_mem_op_q;
            mem_wb_dest_q  <= ex_mem_dest_q;
            mem_wb_we_q    <= ex_mem_we_q;
            mem_wb_data_q  <= (ex_mem_op_q == OP_LW) ? mem_rdata : ex_mem_alu_q;

            ex_mem_valid_q <= id_ex_valid_q;
            ex_mem_op_q    <= id_ex_op_q;
            ex_mem_dest_q  <= id_ex_dest_q;
            ex_mem_we_q    <= id_ex_we_q;
            ex_mem_alu_q   <= ex_alu_d;
            ex_mem_b_q     <= ex_b_d;

            id_ex_valid_q <= if_id_valid_q && !ex_taken_d;
            id_ex_op_q    <= id_op_d;
            id_ex_rs_q    <= id_rs_d;
            id_ex_rt_q    <= id_rt_d;
            id_ex_dest_q  <= id_dest_d;
            id_ex_we_q    <= id_we_d;
            id_ex_a_q     <= id_a_d;
            id_ex_b_q     <= id_b_d;
            id_ex_imm_q   <= id_imm_d;
            id_ex_npc_q   <= if_id_npc_q;

            // A taken branch outranks HLT in ID: that HLT is on the wrong path.
            if (ex_taken_d) begin
                PC            <= ex_target_d;
                if_id_valid_q <= 1'b0;
            end else if (stop_fetch_q || id_hlt_d) begin
                stop_fetch_q  <= 1'b1;
                if_id_valid_q <= 1'b0;
            end else begin
                if_id_valid_q <= 1'b1;
                if_id_ir_q    <= inst_mem[PC[AW-1:0]];
                if_id_npc_q   <= PC + 32'd1;
                PC            <= PC + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_mips.sv
// Bench for pipe_mips: directed program table, halt/reset sequences, and
// random programs checked against an instruction-level interpreter with a timing formula.
module tb_pipe_mips;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halted;

    always #5 clk = ~clk;

    pipe_mips #(.MEM_DEPTH(1024)) dut (
        .clk    (clk),
        .rst    (rst),
        .halted (halted)
    );

    typedef struct packed {
        logic        is_mem;
        logic [9:0]  idx;
        logic [31:0] val;
    } chk_t;

    typedef struct packed {
        logic [4:0]        len;
        logic [15:0][31:0] prog;
        logic [9:0]        maddr;
        logic [31:0]       mval;
        logic [2:0]        nchk;
        chk_t [5:0]        chk;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    vec_t        vecs [0:4];
    logic [31:0] prog_img [0:1023];
    logic [31:0] init_reg [0:31];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:1023];
    logic [31:0] exp_reg [0:31];
    int unsigned tr_edge [$];
    logic [4:0]  tr_dest [$];
    logic [31:0] tr_old [$];
    logic [31:0] tr_new [$];
    int unsigned m_halt_edge;
    logic [31:0] m_final_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic chk_t mk(input logic m, input int unsigned idx, input logic [31:0] v);
        chk_t c;
        c.is_mem = m;
        c.idx    = 10'(idx);
        c.val    = v;
        return c;
    endfunction

    // Sequential ISA interpreter; instruction number d after reset writes back at
    // edge d+5 plus 2 per earlier taken branch.
    task automatic model_run();
        logic [31:0] pc, ir, a, b, imm, v, addr;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, dst;
        int unsigned d, t, wbe;
        bit          wr, taken, done;
        for (int i = 0; i < 1024; i++) m_mem[i] = prog_img[i];
        for (int k = 0; k < 32; k++) m_reg[k] = init_reg[k];
        tr_edge.delete(); tr_dest.delete(); tr_old.delete(); tr_new.delete();
        pc = '0; d = 0; t = 0; done = 0; m_halt_edge = 0; m_final_pc = '0;
        while (!done && d < 4000) begin
            ir  = m_mem[pc[9:0]];
            op  = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
            a   = m_reg[rs]; b = m_reg[rt];
            imm = {{16{ir[15]}}, ir[15:0]};
            wbe = d + 5 + 2 * t;
            wr = 0; taken = 0; dst = rt; v = '0;
            case (op)
                6'd0:  begin v = a + b; dst = rd; wr = 1; end
                6'd1:  begin v = a - b; dst = rd; wr = 1; end
                6'd2:  begin v = a & b; dst = rd; wr = 1; end
                6'd3:  begin v = a | b; dst = rd; wr = 1; end
                6'd4:  begin v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; dst = rd; wr = 1; end
                6'd5:  begin v = a * b; dst = rd; wr = 1; end
                6'd10: begin v = a + imm; wr = 1; end
                6'd11: begin v = a - imm; wr = 1; end
                6'd12: begin v = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; wr = 1; end
                6'd8:  begin addr = a + imm; v = m_mem[addr[9:0]]; wr = 1; end
                6'd9:  begin addr = a + imm; m_mem[addr[9:0]] = b; end
                6'd13: taken = (a != 0);
                6'd14: taken = (a == 0);
                6'd63: begin done = 1; m_halt_edge = wbe; m_final_pc = pc + 1; end
                default: ;
            endcase
            if (wr && dst != 0) begin
                tr_edge.push_back(wbe); tr_dest.push_back(dst);
                tr_old.push_back(m_reg[dst]); tr_new.push_back(v);
                m_reg[dst] = v;
            end
            d++;
            if (taken) begin
                pc = pc + 1 + imm;
                t++;
            end else if (!done) begin
                pc = pc + 1;
            end
        end
    endtask

    task automatic regs_at_edge(input int unsigned e);
        for (int k = 0; k < 32; k++) exp_reg[k] = init_reg[k];
        for (int j = 0; j < tr_edge.size(); j++)
            if (tr_edge[j] <= e) exp_reg[tr_dest[j]] = tr_new[j];
    endtask

    task automatic start();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.inst_mem[i] = prog_img[i];
        for (int k = 0; k < 32; k++) dut.reg_bank[k] = init_reg[k];
        rst = 1'b0;
    endtask

    task automatic run_to_halt(output int unsigned cyc);
        cyc = 0;
        while (!halted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_full(input string tag, input int unsigned cyc);
        check({tag, " halted"}, 32'(halted), 32'd1);
        check({tag, " halt_cycle"}, cyc, m_halt_edge);
        check({tag, " pc"}, dut.PC, m_final_pc);
        for (int k = 0; k < 32; k++)
            check($sformatf("%s r%0d", tag, k), dut.reg_bank[k], m_reg[k]);
    endtask

    task automatic gen_prog(input int unsigned len);
        logic [4:0] prev_rt;
        bit         prev_lw;
        for (int i = 0; i < 1024; i++) prog_img[i] = '0;
        prev_lw = 0; prev_rt = '0;
        for (int i = 0; i < int'(len); i++) begin
            int unsigned k, maxoff;
            logic [5:0]  op;
            logic [4:0]  rs, rt, rd;
            logic [15:0] imm;
            logic [31:0] ins;
            k   = $urandom_range(0, 9);
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 7));
            imm = 16'($urandom);
            op  = 6'b010000;
            case (k)
                0, 1, 2, 3: begin op = 6'($urandom_range(0, 5)); imm = {rd, 11'd0}; end
                4, 5:       op = 6'($urandom_range(10, 12));
                6:          begin op = 6'd8; rs = '0; rt = 5'($urandom_range(1, 7)); imm = 16'(700 + $urandom_range(0, 15)); end
                7:          begin op = 6'd9; rs = '0; imm = 16'(700 + $urandom_range(0, 15)); end
                8: begin
                    op     = ($urandom_range(0, 1) == 0) ? 6'd13 : 6'd14;
                    maxoff = int'(len) - 1 - i;
                    if (maxoff > 3) maxoff = 3;
                    imm    = 16'($urandom_range(0, maxoff));
                end
                default: ;
            endcase
            ins = {op, rs, rt, imm};
            if (prev_lw && (rs == prev_rt || rt == prev_rt))
                ins = '0;
            prev_lw = (ins[31:26] == 6'd8);
            prev_rt = ins[20:16];
            prog_img[i] = ins;
        end
        prog_img[len] = 32'hfc000000;
        for (int a = 700; a < 716; a++) prog_img[a] = $urandom;
    endtask

    initial begin
        int unsigned cyc, e_r;
        for (int v = 0; v < 5; v++) vecs[v] = '0;

        vecs[0].len = 5'd6;
        vecs[0].prog[0] = 32'h2801000a; vecs[0].prog[1] = 32'h28020014; vecs[0].prog[2] = 32'h28030019;
        vecs[0].prog[3] = 32'h00222000; vecs[0].prog[4] = 32'h00832800; vecs[0].prog[5] = 32'hfc000000;
        vecs[0].nchk = 3'd5;
        vecs[0].chk[0] = mk(0, 1, 10); vecs[0].chk[1] = mk(0, 2, 20); vecs[0].chk[2] = mk(0, 3, 25);
        vecs[0].chk[3] = mk(0, 4, 30); vecs[0].chk[4] = mk(0, 5, 55);

        vecs[1].len = 5'd7;
        vecs[1].prog[0] = 32'h28010078; vecs[1].prog[1] = 32'h20220000; vecs[1].prog[2] = 32'h0c631800;
        vecs[1].prog[3] = 32'h2842002d; vecs[1].prog[4] = 32'h0c631800; vecs[1].prog[5] = 32'h24220001;
        vecs[1].prog[6] = 32'hfc000000;
        vecs[1].maddr = 10'd120; vecs[1].mval = 32'd85;
        vecs[1].nchk = 3'd2;
        vecs[1].chk[0] = mk(0, 2, 130); vecs[1].chk[1] = mk(1, 121, 130);

        vecs[2].len = 5'd11;
        vecs[2].prog[0] = 32'h280a00c8; vecs[2].prog[1] = 32'h28020001; vecs[2].prog[2]  = 32'h0e94a000;
        vecs[2].prog[3] = 32'h21430000; vecs[2].prog[4] = 32'h0e94a000; vecs[2].prog[5]  = 32'h14431000;
        vecs[2].prog[6] = 32'h2c630001; vecs[2].prog[7] = 32'h0e94a000; vecs[2].prog[8]  = 32'h3460fffc;
        vecs[2].prog[9] = 32'h2542fffe; vecs[2].prog[10] = 32'hfc000000;
        vecs[2].maddr = 10'd200; vecs[2].mval = 32'd7;
        vecs[2].nchk = 3'd4;
        vecs[2].chk[0] = mk(1, 198, 5040); vecs[2].chk[1] = mk(0, 2, 5040);
        vecs[2].chk[2] = mk(0, 3, 0);      vecs[2].chk[3] = mk(0, 10, 200);

        vecs[3].len = 5'd6;
        vecs[3].prog[0] = 32'h38000002; vecs[3].prog[1] = 32'h2809006f; vecs[3].prog[2] = 32'h280900de;
        vecs[3].prog[3] = 32'h38200001; vecs[3].prog[4] = 32'h2808004d; vecs[3].prog[5] = 32'hfc000000;
        vecs[3].nchk = 3'd2;
        vecs[3].chk[0] = mk(0, 9, 9); vecs[3].chk[1] = mk(0, 8, 77);

        vecs[4].len = 5'd6;
        vecs[4].prog[0] = 32'h28010003; vecs[4].prog[1] = 32'h00211000; vecs[4].prog[2] = 32'h00411800;
        vecs[4].prog[3] = 32'h00622000; vecs[4].prog[4] = 32'h28000005; vecs[4].prog[5] = 32'hfc000000;
        vecs[4].nchk = 3'd4;
        vecs[4].chk[0] = mk(0, 2, 6); vecs[4].chk[1] = mk(0, 3, 9);
        vecs[4].chk[2] = mk(0, 4, 15); vecs[4].chk[3] = mk(0, 0, 0);

        for (int k = 0; k < 32; k++) init_reg[k] = 32'(k);

        start();
        check("reset halted", 32'(halted), 32'd0);
        check("reset pc", dut.PC, 32'd0);
        check("reset taken", 32'(dut.TAKEN_BRANCH), 32'd0);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 1024; i++) prog_img[i] = '0;
            for (int i = 0; i < int'(vecs[v].len); i++) prog_img[i] = vecs[v].prog[i];
            if (vecs[v].maddr != '0) prog_img[vecs[v].maddr] = vecs[v].mval;
            for (int k = 0; k < 32; k++) init_reg[k] = 32'(k);
            model_run();
            start();
            run_to_halt(cyc);
            check($sformatf("case%0d halted", v + 1), 32'(halted), 32'd1);
            check($sformatf("case%0d halt_cycle", v + 1), cyc, m_halt_edge);
            for (int c = 0; c < int'(vecs[v].nchk); c++) begin
                if (vecs[v].chk[c].is_mem)
                    check($sformatf("case%0d m%0d", v + 1, vecs[v].chk[c].idx),
                          dut.inst_mem[vecs[v].chk[c].idx], vecs[v].chk[c].val);
                else
                    check($sformatf("case%0d r%0d", v + 1, vecs[v].chk[c].idx),
                          dut.reg_bank[vecs[v].chk[c].idx[4:0]], vecs[v].chk[c].val);
            end
        end

        // Halt freeze: rerun factorial and hold for 10 cycles after HLT.
        for (int i = 0; i < 1024; i++) prog_img[i] = '0;
        for (int i = 0; i < 11; i++) prog_img[i] = vecs[2].prog[i];
        prog_img[200] = 32'd7;
        for (int k = 0; k < 32; k++) init_reg[k] = 32'(k);
        model_run();
        start();
        run_to_halt(cyc);
        repeat (10) @(negedge clk);
        check_full("frozen", cyc);
        for (int a = 0; a < 256; a++)
            check($sformatf("frozen m%0d", a), dut.inst_mem[a], m_mem[a]);

        // Reset on an edge where a loop write-back would otherwise land.
        e_r = 20;
        for (int j = tr_edge.size() - 1; j >= 0; j--)
            if (tr_edge[j] >= 20 && tr_new[j] != tr_old[j]) e_r = tr_edge[j];
        start();
        cyc = 0;
        while (cyc < e_r - 1) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        regs_at_edge(e_r - 1);
        check("midrst pc", dut.PC, 32'd0);
        check("midrst halted", 32'(halted), 32'd0);
        check("midrst taken", 32'(dut.TAKEN_BRANCH), 32'd0);
        for (int k = 0; k < 32; k++)
            check($sformatf("midrst r%0d", k), dut.reg_bank[k], exp_reg[k]);
        for (int k = 0; k < 32; k++) init_reg[k] = exp_reg[k];
        model_run();
        rst = 1'b0;
        run_to_halt(cyc);
        check_full("rerun", cyc);
        check("rerun m198", dut.inst_mem[198], 32'd5040);

        for (int p = 0; p < 6; p++) begin
            gen_prog(24);
            for (int k = 0; k < 32; k++) init_reg[k] = 32'(k);
            model_run();
            start();
            run_to_halt(cyc);
            check_full($sformatf("rand%0d", p), cyc);
            for (int a = 700; a < 716; a++)
                check($sformatf("rand%0d m%0d", p, a), dut.inst_mem[a], m_mem[a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
